cpu_step_ctrl: RTL and testbench
================================

# cpu_step_ctrl

Execution sequencer for the single-cycle 8-bit processor datapath (program counter, register file, parallel output port). All datapath state elements run on the 50 MHz clock, and this block issues the one-cycle `cpu_en` that advances them. It provides free-run at a divided rate, single-step from a push button, and an optional PC breakpoint halt. It also keeps an executed-instruction counter for the display.

## Interface
Parameters:
- `TICK_DIV`, default 25000000: clock cycles between run-mode enables (≥2).
- `DB_CYCLES`, default 500000: cycles the step button must stay stable to be accepted (≥1).
- `PC_W`, default 8: width of `pc` and `bkpt_pc`.

Ports:
- `clk`: in, 1. System clock; all logic on its rising edge.
- `rst`: in, 1. Synchronous, active-high reset.
- `run_sw`: in, 1. Level; 1 requests free-run, 0 requests single-step.
- `step_btn`: in, 1. Raw, asynchronous, active-high step/resume button.
- `pc`: in, PC_W. Current program counter (address of the next instruction).
- `bkpt_pc`: in, PC_W. Breakpoint address.
- `bkpt_sw`: in, 1. Breakpoint enable.
- `cpu_en`: out, 1. One-cycle datapath advance strobe.
- `state`: out, 2. FSM state: IDLE=00, RUN=01, STEP=10, HALT=11.
- `halted`: out, 1. High while in HALT.
- `cyc_cnt`: out, 16. Number of `cpu_en` pulses issued.

## Operation
- **Button path:**
  - 2-flop synchronizer on `step_btn`.
  - A debounce counter increments each cycle the synchronized value differs from the debounced level. It clears when the two agree.
  - When the counter reaches DB_CYCLES and the values still differ, the debounced level flips.
  - A rising edge of the debounced level is a press event: exactly one per press, regardless of hold time.
- **IDLE:**
  - If `run_sw`=1, go to RUN.
  - Otherwise a press event goes to STEP and issues one `cpu_en`.
- **RUN:**
  - The tick counter counts 0..TICK_DIV-1 and wraps.
  - At terminal count, `cpu_en`=1 for one cycle, unless the breakpoint condition holds.
  - If `run_sw`=0, go to STEP and clear the tick counter. This takes priority over a same-cycle tick, so no pulse is issued.
  - Press events are ignored.
- **STEP:**
  - Each press event issues one `cpu_en`.
  - If `run_sw`=1, go to RUN with the tick counter cleared.
  - If a press event and `run_sw`=1 occur in the same cycle, the pulse is issued and the state moves to RUN.
  - No breakpoint check in STEP.
- **Breakpoint** (STEP_BKPT_EN only):
  - Condition: RUN at terminal count with `bkpt_sw`=1 and `pc`==`bkpt_pc`.
  - Response: no pulse; go to HALT. The instruction at `bkpt_pc` is not executed.
- **HALT:**
  - `run_sw` is ignored.
  - A press event issues one `cpu_en` (executes the breakpoint instruction) and goes to STEP. From STEP, RUN resumes if `run_sw`=1.
  - A self-loop at `bkpt_pc` re-halts on the next run tick.
- **`cyc_cnt`:** increments in the cycle after each `cpu_en`; wraps 0xFFFF→0x0000.

## Timing
- **Reset values:** `state`=IDLE, `cpu_en`=0, `halted`=0, `cyc_cnt`=0. Tick counter, debounce counter, synchronizer and debounced level are all 0.
- **Reset mid-operation:** reset wins over every event; outputs take reset values at the next edge.
- **`cpu_en`:** registered, high for exactly one cycle. Never high in consecutive cycles (TICK_DIV≥2, and press events are at least DB_CYCLES apart).
- **Step latency:** `step_btn` high at edge 0 and held gives `cpu_en` high after edge DB_CYCLES+3. A glitch shorter than DB_CYCLES cycles produces no pulse.
- **Run cadence:** first `cpu_en` after edge TICK_DIV following RUN entry, then every TICK_DIV cycles.
- **HALT entry:** registered; `state`=HALT and `halted`=1 in the cycle after the terminal count.
- **`cyc_cnt`:** lags `cpu_en` by one cycle.

## Configuration
- **`STEP_BKPT_EN` defined:** breakpoint comparison and the HALT state are implemented as above.
- **`STEP_BKPT_EN` undefined:**
  - `bkpt_pc` and `bkpt_sw` are ignored.
  - HALT is unreachable; `halted` is tied to 0.
  - RUN terminal count always pulses.

## Test plan
All scenarios use TICK_DIV=10, DB_CYCLES=4, STEP_BKPT_EN defined.
- **Reset then step:** reset, `run_sw`=0, hold `step_btn`=1 for 20 cycles → exactly one `cpu_en`, after edge 7; `state`=STEP; `cyc_cnt`=1.
- **Bounce rejection:** `step_btn` toggles every 2 cycles for 30 cycles, then stays 0 → no `cpu_en`; debounced level remains 0.
- **Free run:** `run_sw`=1 for 55 cycles from IDLE → `state`=RUN, `cpu_en` on cycles 10, 20, 30, 40, 50 (5 pulses); `cyc_cnt`=5.
- **Breakpoint:** RUN with a PC model incrementing on `cpu_en`, `bkpt_pc`=3, `bkpt_sw`=1 → pulses at PC 0, 1, 2 only. At the next tick `state`=HALT and `halted`=1. A press gives one pulse, `pc`=4, `state`=STEP, then RUN resumes.
- **Priority:** `run_sw` falls in the terminal-count cycle → no pulse, `state`=STEP, tick counter 0. Reset asserted while in HALT → `state`=IDLE and `cyc_cnt`=0 next cycle.
- **Wrap:** preload `cyc_cnt`=0xFFFF via a forced run, issue one step → `cyc_cnt`=0x0000.

Source files
------------

// File: rtl/cpu_step_ctrl.sv
// rtl/cpu_step_ctrl.sv - execution sequencer: free-run ticks, debounced single-step, PC breakpoint halt.
// Optional feature macro: STEP_BKPT_EN (breakpoint compare and HALT state).
module cpu_step_ctrl #(
    parameter int TICK_DIV  = 25000000,
    parameter int DB_CYCLES = 500000,
    parameter int PC_W      = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run_sw,
    input  logic            step_btn,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] bkpt_pc,
    input  logic            bkpt_sw,
    output logic            cpu_en,
    output logic [1:0]      state,
    output logic            halted,
    output logic [15:0]     cyc_cnt
);
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_STEP = 2'b10;
    localparam logic [1:0] S_HALT = 2'b11;

    localparam int TW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DB_CYCLES + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES);

    logic          r_sync1, r_sync2, r_db_level, r_db_prev;
    logic [DW-1:0] r_db_cnt;
    logic [1:0]    r_state;
    logic [TW-1:0] r_tick;
    logic          r_cpu_en;
    logic [15:0]   r_cyc_cnt;

    logic          w_press, w_tick, w_bkpt, w_en_nxt;
    logic [1:0]    w_state_nxt;
    logic [TW-1:0] w_tick_nxt;

    // The debounced level only flips after the synchronized input disagrees for DB_CYCLES+1 edges
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_db_level <= 1'b0;
            r_db_prev  <= 1'b0;
            r_db_cnt   <= '0;
        end else begin
            r_sync1   <= step_btn;
            r_sync2   <= r_sync1;
            r_db_prev <= r_db_level;
            if (r_sync2 == r_db_level) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_db_level <= r_sync2;
                r_db_cnt   <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DW'(1);
            end
        end
    end

    assign w_press = r_db_level & ~r_db_prev;
    assign w_tick  = (r_tick == TICK_LAST);

`ifdef STEP_BKPT_EN
    assign w_bkpt = w_tick & bkpt_sw & (pc == bkpt_pc);
    assign halted = (r_state == S_HALT);
`else
    logic w_unused;
    assign w_unused = ^{pc, bkpt_pc, bkpt_sw};
    assign w_bkpt   = 1'b0;
    assign halted   = 1'b0;
`endif

    // Run-switch release beats a same-cycle tick; tick counter is held at zero outside RUN
    always_comb begin
        w_state_nxt = r_state;
        w_en_nxt    = 1'b0;
        w_tick_nxt  = '0;
        case (r_state)
            S_IDLE: begin
                if (run_sw) begin
                    w_state_nxt = S_RUN;
                end else if (w_press) begin
                    w_state_nxt = S_STEP;
                    w_en_nxt    = 1'b1;
                end
            end
            S_RUN: begin
                if (!run_sw) begin
                    w_state_nxt = S_STEP;
                end else if (w_tick) begin
                    if (w_bkpt) w_state_nxt = S_HALT;
                    else        w_en_nxt    = 1'b1;
                end else begin
                    w_tick_nxt = r_tick + TW'(1);
                end
            end
            S_STEP: begin
                if (w_press) w_en_nxt    = 1'b1;
                if (run_sw)  w_state_nxt = S_RUN;
            end
            S_HALT: begin
                if (w_press) begin
                    w_en_nxt    = 1'b1;
                    w_state_nxt = S_STEP;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_tick    <= '0;
            r_cpu_en  <= 1'b0;
            r_cyc_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_tick    <= w_tick_nxt;
            r_cpu_en  <= w_en_nxt;
            r_cyc_cnt <= r_cyc_cnt + {15'd0, r_cpu_en};
        end
    end

    assign cpu_en  = r_cpu_en;
    assign state   = r_state;
    assign cyc_cnt = r_cyc_cnt;
endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb/tb_cpu_step_ctrl.sv - scoreboard bench for cpu_step_ctrl with TICK_DIV=10, DB_CYCLES=4.
`timescale 1ns/1ps
module tb_cpu_step_ctrl;
    localparam int TD  = 10;
    localparam int DB  = 4;
    localparam int LAT = DB + 3;
`ifdef STEP_BKPT_EN
    localparam bit BKPT = 1'b1;
`else
    localparam bit BKPT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run_sw = 1'b0;
    logic        step_btn = 1'b0;
    logic        bkpt_sw = 1'b0;
    logic [7:0]  bkpt_pc = 8'd0;
    logic [7:0]  pc;
    logic        cpu_en, halted;
    logic [1:0]  state;
    logic [15:0] cyc_cnt;

    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    int          n_pulses = 0;
    int          pc_mark = 0;
    logic [15:0] exp_cnt = 16'd0;

    typedef struct {
        int          at;
        logic [15:0] cnt;
    } pulse_t;
    pulse_t sb[$];

    // Environment datapath: PC advances once per issued cpu_en
    assign pc = 8'(n_pulses - pc_mark);

    cpu_step_ctrl #(.TICK_DIV(TD), .DB_CYCLES(DB), .PC_W(8)) dut (
        .clk(clk), .rst(rst), .run_sw(run_sw), .step_btn(step_btn),
        .pc(pc), .bkpt_pc(bkpt_pc), .bkpt_sw(bkpt_sw),
        .cpu_en(cpu_en), .state(state), .halted(halted), .cyc_cnt(cyc_cnt)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin : monitor
        pulse_t p;
        while (sb.size() > 0 && sb[0].at < cyc) begin
            p = sb.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing_pulse: cpu_en=0 at cycle %0d, required 1", p.at);
        end
        if (cpu_en === 1'b1) begin
            n_pulses++;
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pulse: cpu_en=1 at cycle %0d, required 0", cyc);
            end else begin
                p = sb.pop_front();
                if (p.at != cyc || p.cnt !== cyc_cnt) begin
                    miscompares++;
                    $display("FAIL pulse: got cycle %0d cyc_cnt %h, required cycle %0d cyc_cnt %h",
                             cyc, cyc_cnt, p.at, p.cnt);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic expect_pulse(input int at);
        pulse_t p;
        p.at  = at;
        p.cnt = exp_cnt;
        sb.push_back(p);
        exp_cnt = exp_cnt + 16'd1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        chk("rst_state", int'(state), 0);
        chk("rst_cpu_en", int'(cpu_en), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_cyc_cnt", int'(cyc_cnt), 0);
        rst = 1'b0;
        sb.delete();
        exp_cnt = 16'd0;
    endtask

    // Press held for 'hold' cycles; a pulse follows only if held longer than DB cycles
    task automatic press(input int hold, input int gap, input bit accepted);
        step_btn = 1'b1;
        if (accepted && hold > DB) expect_pulse(cyc + 1 + LAT);
        tick(hold);
        step_btn = 1'b0;
        tick(gap);
    endtask

    // Free-run for L cycles, then drop run_sw; ticks land every TD edges after RUN entry
    task automatic run_for(input int L);
        int c;
        c = cyc;
        run_sw = 1'b1;
        for (int k = 1; TD * k + 1 <= L; k++) expect_pulse(c + 1 + TD * k);
        tick(L);
        chk("run_state", int'(state), 1);
        run_sw = 1'b0;
        tick(1);
        chk("run_stop_state", int'(state), 2);
        chk("run_cyc_cnt", int'(cyc_cnt), int'(exp_cnt));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int c, b, hold, L;
        tick(2);
        do_reset();

        // Single step held for 20 cycles from IDLE
        press(20, 10, 1'b1);
        chk("step_state", int'(state), 2);
        chk("step_cyc_cnt", int'(cyc_cnt), 1);

        // Boundary holds DB and DB+1, then random holds
        for (int i = 0; i < 8; i++) begin
            hold = (i == 0) ? DB : (i == 1) ? DB + 1 : int'($urandom_range(1, 12));
            press(hold, int'($urandom_range(8, 12)), 1'b1);
        end
        chk("steps_cyc_cnt", int'(cyc_cnt), int'(exp_cnt));
        chk("steps_state", int'(state), 2);

        // Bouncing button never produces a press
        repeat (15) begin
            step_btn = ~step_btn;
            tick(2);
        end
        step_btn = 1'b0;
        tick(12);
        chk("bounce_cyc_cnt", int'(cyc_cnt), int'(exp_cnt));

        // Free run from IDLE, then runs including run_sw falling on the terminal count
        do_reset();
        run_for(55);
        for (int i = 0; i < 4; i++) begin
            L = (i == 0) ? TD * int'($urandom_range(2, 4)) : int'($urandom_range(15, 45));
            run_for(L);
            tick(int'($urandom_range(3, 8)));
        end

        // Breakpoint: halt then press-resume, then halt and reset while halted
        bkpt_sw = 1'b1;
        for (int it = 0; it < 2; it++) begin
            b = (it == 0) ? 3 : int'($urandom_range(1, 4));
            bkpt_pc = 8'(b);
            pc_mark = n_pulses;
            c = cyc;
            if (BKPT) begin
                for (int k = 1; k <= b; k++) expect_pulse(c + 1 + TD * k);
                if (it == 0) begin
                    expect_pulse(c + TD * b + 26 + LAT + 1);
                    expect_pulse(c + TD * b + 26 + 19);
                end
            end else begin
                L = (it == 0) ? TD * b + 46 : TD * b + 26;
                for (int k = 1; TD * k + 1 <= L; k++) expect_pulse(c + 1 + TD * k);
            end
            run_sw = 1'b1;
            tick(TD * b + 11);
            chk("bkpt_state", int'(state), BKPT ? 3 : 1);
            chk("bkpt_halted", int'(halted), BKPT ? 1 : 0);
            tick(15);
            chk("bkpt_hold_state", int'(state), BKPT ? 3 : 1);
            if (it == 0) begin
                step_btn = 1'b1;
                tick(6);
                step_btn = 1'b0;
                tick(2);
                chk("resume_state", int'(state), BKPT ? 2 : 1);
                tick(1);
                chk("resume_run_state", int'(state), 1);
                chk("resume_pc", int'(pc), BKPT ? b + 1 : b + 3);
                tick(11);
                run_sw = 1'b0;
                tick(1);
                chk("resume_stop_state", int'(state), 2);
                chk("resume_cyc_cnt", int'(cyc_cnt), int'(exp_cnt));
                tick(5);
            end else begin
                run_sw = 1'b0;
                do_reset();
            end
        end

        // Counter wrap: preload 0xFFFF, one step rolls it to zero
        force dut.r_cyc_cnt = 16'hFFFF;
        tick(1);
        release dut.r_cyc_cnt;
        exp_cnt = 16'hFFFF;
        tick(1);
        chk("wrap_preload", int'(cyc_cnt), 16'hFFFF);
        press(10, 10, 1'b1);
        chk("wrap_cyc_cnt", int'(cyc_cnt), 0);
        chk("wrap_state", int'(state), 2);

        tick(2 * TD);
        chk("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
